booth_ctrl: RTL and testbench
=============================

# booth_ctrl

Sequencing control unit for the ALU's radix-2 Booth multiplier. It produces the one-hot load, clear and shift enables that drive the A, Q and M datapath registers, and the add/subtract select for the adder. It reads back Q[0] and Q[-1] to decide each iteration. It sits directly upstream of the shift/load registers; each control output is wired straight to a register's enable or select pin.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be a power of two, at least 2.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; clock is clk.
- start  input  1  request a multiplication; sampled only in IDLE.
- q0  input  1  current Q[0] from the Q register.
- q_m1  input  1  current Q[-1] extension bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse in OUT_Q.
- ld_m  output  1  load M from inbus.
- ld_q  output  1  load Q from inbus.
- clr_a  output  1  clear A and Q[-1].
- ld_a  output  1  load A from adder output.
- sub  output  1  adder computes A−M when high, A+M when low.
- shr  output  1  arithmetic right shift of {A,Q,Q[-1]}; A's MSB feeds back into itself.
- out_a  output  1  drive A onto outbus (product high half).
- out_q  output  1  drive Q onto outbus (product low half).

## Operation
States and transitions:
- IDLE: all control outputs 0. start=1 → LOAD_M.
- LOAD_M: ld_m=1 → LOAD_Q.
- LOAD_Q: ld_q=1, clr_a=1, counter cleared to 0 → TEST.
- TEST: ld_a = q0^q_m1, sub = q0 & ~q_m1. These are Mealy outputs, combinational from q0/q_m1. Always → SHIFT.
- SHIFT: shr=1, counter increments. If the counter was WIDTH−1 → OUT_A, else → TEST.
- OUT_A: out_a=1 → OUT_Q.
- OUT_Q: out_q=1, done=1 → IDLE.

Rules:
- sub is 0 in every state other than TEST.
- At most one of ld_m, ld_q, ld_a, shr, out_a, out_q is high in any cycle. clr_a is high only together with ld_q.
- Counter arithmetic is unsigned, modulo 2^CNT_W. The wrap from WIDTH−1 is never used because the FSM leaves SHIFT at that point.
- start is ignored while busy.
- If start is high in the cycle after OUT_Q (IDLE), a new operation begins.

## Timing
- Reset: state IDLE, counter 0. Every output is 0, including busy and done.
- Reset asserted mid-operation forces IDLE and all-zero outputs immediately (asynchronous). There is no partial completion.
- start is sampled at rising edge k. LOAD_M occupies cycle k+1. There are WIDTH TEST/SHIFT pairs in total. OUT_Q (done) occupies cycle k+2·WIDTH+4, which is cycle k+20 for WIDTH=8.
- Total busy duration is 2·WIDTH+4 cycles.
- q0/q_m1 must be stable, reflecting register contents, from the clock edge entering TEST. The downstream register captures ld_a/sub at the edge leaving TEST.
- ld_a and shr are never asserted in the same cycle, so adder results are settled before the shift.

## Structure
- Shared package booth_ctrl_pkg holds:
  - the state encoding constants: IDLE, LOAD_M, LOAD_Q, TEST, SHIFT, OUT_A, OUT_Q (binary, 3 bits);
  - the default WIDTH.
- One sub-module, iter_cnt: a CNT_W-bit counter with clear, increment, and a last flag (count == WIDTH−1), with asynchronous active-low reset.
- The FSM next-state logic and output decode live in booth_ctrl.

## Test plan
The bench instantiates a behavioural A/Q/Q[-1]/M datapath driven by the control outputs, with WIDTH=8.
1. Reset held low with clocks running → every output 0. After release, busy=0 and no output toggles without start.
2. q0/q_m1 tied 00, 1-cycle start pulse → exact sequence LOAD_M, LOAD_Q, 8×(TEST with ld_a=0, SHIFT), OUT_A, OUT_Q. Exactly 8 shr pulses and 0 ld_a pulses; done at start edge +20.
3. Datapath model, M=8'd7, Q=8'hFD (−3) → outbus reads A=8'hFF then Q=8'hEB (−21). The number of ld_a pulses with sub=1 matches the count of 10 pairs seen by TEST.
4. M=8'h80, Q=8'h80 (−128×−128) → A=8'h40, Q=8'h00 (16384). Check that no two enables are ever high together (assertion over the whole run).
5. A second start pulse mid-operation is ignored and the result is unchanged. start held high through OUT_Q → the next operation's LOAD_M starts exactly 2 cycles after done.
6. Reset pulsed low during the 3rd SHIFT → all outputs 0 within the same cycle. A following start runs the full 20-cycle sequence and produces the correct product.

Source files
------------

// File: rtl/booth_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer.
package booth_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        TEST   = 3'd3,
        SHIFT  = 3'd4,
        OUT_A  = 3'd5,
        OUT_Q  = 3'd6
    } state_t;

endpackage

// File: rtl/booth_ctrl_iter_cnt.sv
// Iteration counter for the Booth loop: clear, increment, and a flag on the
// final iteration (count == WIDTH-1).
import booth_ctrl_pkg::*;

module iter_cnt #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; increment wraps modulo 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Booth multiplier sequencer: walks LOAD_M, LOAD_Q, WIDTH x (TEST, SHIFT),
// OUT_A, OUT_Q and drives the one-hot datapath enables. ld_a/sub in TEST are
// decoded straight from q0/q_m1 so the adder result is captured on the edge
// leaving TEST, one cycle before the shift.
import booth_ctrl_pkg::*;

module booth_ctrl #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic q_m1,
    output logic busy,
    output logic done,
    output logic ld_m,
    output logic ld_q,
    output logic clr_a,
    output logic ld_a,
    output logic sub,
    output logic shr,
    output logic out_a,
    output logic out_q
);

    state_t state_q, state_d;
    logic   cnt_last;

    iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == LOAD_Q),
        .inc   (state_q == SHIFT),
        .last  (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD_M;
            LOAD_M:  state_d = LOAD_Q;
            LOAD_Q:  state_d = TEST;
            TEST:    state_d = SHIFT;
            SHIFT:   state_d = cnt_last ? OUT_A : TEST;
            OUT_A:   state_d = OUT_Q;
            OUT_Q:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; every output defaults low so IDLE and reset are all-zero.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        ld_m  = 1'b0;
        ld_q  = 1'b0;
        clr_a = 1'b0;
        ld_a  = 1'b0;
        sub   = 1'b0;
        shr   = 1'b0;
        out_a = 1'b0;
        out_q = 1'b0;
        case (state_q)
            LOAD_M: begin
                busy = 1'b1;
                ld_m = 1'b1;
            end
            LOAD_Q: begin
                busy  = 1'b1;
                ld_q  = 1'b1;
                clr_a = 1'b1;
            end
            TEST: begin
                busy = 1'b1;
                ld_a = q0 ^ q_m1;
                sub  = q0 & ~q_m1;
            end
            SHIFT: begin
                busy = 1'b1;
                shr  = 1'b1;
            end
            OUT_A: begin
                busy  = 1'b1;
                out_a = 1'b1;
            end
            OUT_Q: begin
                busy  = 1'b1;
                out_q = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: a behavioural A/Q/Q[-1]/M datapath follows the
// control outputs; each operation's expected product and pulse counts come
// from plain signed multiplication and the operand's bit pairs, queued at
// issue time and popped by a monitor when out_q appears.
module tb_booth_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic q0, q_m1;
    logic busy, done, ld_m, ld_q, clr_a, ld_a, sub, shr, out_a, out_q;

    booth_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .q0(q0), .q_m1(q_m1),
        .busy(busy), .done(done), .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a),
        .ld_a(ld_a), .sub(sub), .shr(shr), .out_a(out_a), .out_q(out_q)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Datapath plant; A carries one guard bit so M = -128 cannot overflow.
    logic [W-1:0] m_op = '0, q_op = '0;
    logic [W:0]   pa = '0;
    logic [W-1:0] pq = '0, pm = '0;
    logic         pqm1 = 1'b0;
    logic [W-1:0] inbus, outbus;

    assign inbus  = ld_m ? m_op : q_op;
    assign outbus = out_a ? pa[W-1:0] : (out_q ? pq : '0);
    assign q0     = pq[0];
    assign q_m1   = pqm1;

    always @(posedge clk) begin
        if (ld_m) pm <= inbus;
        if (ld_q) pq <= inbus;
        if (clr_a) begin
            pa   <= '0;
            pqm1 <= 1'b0;
        end
        if (ld_a) pa <= sub ? pa - {pm[W-1], pm} : pa + {pm[W-1], pm};
        if (shr) {pa, pq, pqm1} <= {pa[W], pa, pq};
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] q;
        int subc;
        int ldac;
        int done_e;
    } exp_t;

    exp_t sbq[$];

    function automatic exp_t model(input logic [W-1:0] m, input logic [W-1:0] q, input int de);
        exp_t e;
        logic signed [2*W-1:0] p;
        logic prev;
        p = $signed(m) * $signed(q);
        e.a = p[2*W-1:W];
        e.q = p[W-1:0];
        e.subc = 0;
        e.ldac = 0;
        prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (q[i] && !prev) e.subc++;
            if (q[i] != prev) e.ldac++;
            prev = q[i];
        end
        e.done_e = de;
        return e;
    endfunction

    int total = 0, bad = 0;
    int tmo_req = 0, tmo_seen = 0;
    bit fin = 1'b0, fin_done = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at edge %0d", nm, act, act, exp, exp, edge_n);
        end
    endtask

    // Monitor: per-cycle legality, step-by-step sequence, result scoreboard.
    int pos = 0, seq_err = 0, n_lda = 0, n_sub = 0, n_shr = 0;
    logic [W-1:0] cap_a = '0;
    always @(negedge clk) begin
        logic [5:0] ctl;
        int code, expc;
        bit ok;
        exp_t e;
        ctl = {ld_m, ld_q, ld_a, shr, out_a, out_q};
        if (!reset) begin
            chk("rst_zero", int'({busy, done, clr_a, sub, ctl}), 0);
        end else begin
            ok = ($countones(ctl) <= 1) && (!clr_a || ld_q) && (!sub || ld_a) &&
                 (done == out_q) && (busy || ({done, clr_a, sub, ctl} == 10'd0));
            chk("excl", int'(ok), 1);
            if (busy) begin
                if (ld_m) code = 1;
                else if (ld_q && clr_a) code = 2;
                else if (shr) code = 4;
                else if (out_a) code = 5;
                else if (out_q && done) code = 6;
                else code = 3;
                if (pos == 0) expc = 1;
                else if (pos == 1) expc = 2;
                else if (pos <= 2 * W + 1) expc = (pos % 2 == 0) ? 3 : 4;
                else if (pos == 2 * W + 2) expc = 5;
                else if (pos == 2 * W + 3) expc = 6;
                else expc = 7;
                if (code != expc) seq_err++;
                if (code == 3 && (ld_a != (q0 ^ q_m1) || sub != (q0 & ~q_m1))) seq_err++;
                if (ld_a) n_lda++;
                if (ld_a && sub) n_sub++;
                if (shr) n_shr++;
                if (out_a) cap_a = outbus;
                if (out_q) begin
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("prod_hi", int'(cap_a), int'(e.a));
                        chk("prod_lo", int'(outbus), int'(e.q));
                        chk("sub_pulses", n_sub, e.subc);
                        chk("lda_pulses", n_lda, e.ldac);
                        chk("shr_pulses", n_shr, W);
                        chk("done_edge", edge_n, e.done_e);
                        chk("seq_err", seq_err, 0);
                        chk("busy_len", pos + 1, 2 * W + 4);
                    end
                end
                pos++;
            end else begin
                pos = 0;
                seq_err = 0;
                n_lda = 0;
                n_sub = 0;
                n_shr = 0;
            end
        end
        if (tmo_req != tmo_seen) begin
            chk("timeout", tmo_req, tmo_seen);
            tmo_seen = tmo_req;
        end
        if (fin && !fin_done) begin
            chk("sb_drain", sbq.size(), 0);
            fin_done = 1'b1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4 * W + 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) tmo_req++;
        @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input bit mid);
        @(negedge clk);
        m_op = m;
        q_op = q;
        start = 1'b1;
        sbq.push_back(model(m, q, edge_n + 2 * W + 4));
        @(negedge clk);
        start = 1'b0;
        if (mid) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    // start held through OUT_Q: second operation begins two cycles after done.
    task automatic run_held(input logic [W-1:0] m1, input logic [W-1:0] q1,
                            input logic [W-1:0] m2, input logic [W-1:0] q2);
        int n = 0;
        @(negedge clk);
        m_op = m1;
        q_op = q1;
        start = 1'b1;
        sbq.push_back(model(m1, q1, edge_n + 2 * W + 4));
        @(negedge clk);
        while (!done && n < 4 * W + 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) tmo_req++;
        m_op = m2;
        q_op = q2;
        sbq.push_back(model(m2, q2, edge_n + 2 * W + 5));
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    // Reset pulsed during the 3rd SHIFT; the aborted op expects no result.
    task automatic run_abort(input logic [W-1:0] m, input logic [W-1:0] q);
        int n = 0, k = 0;
        @(negedge clk);
        m_op = m;
        q_op = q;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n < 3 && k < 4 * W) begin
            @(posedge clk);
            #1;
            if (shr) n++;
            k++;
        end
        if (n < 3) tmo_req++;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        run_op(8'hAB, 8'h00, 1'b0);
        run_op(8'd7, 8'hFD, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);
        run_op(8'h5A, 8'hC3, 1'b1);
        run_held(8'h13, 8'h9E, 8'hF1, 8'h7F);
        run_abort(8'h33, 8'h55);
        run_op(8'd7, 8'hFD, 1'b0);
        for (int i = 0; i < 12; i++)
            run_op(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
        run_op(8'h7F, 8'h80, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);
        fin = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
